// File: rtl/elevator_call_scheduler_if.sv
// Elevator call scheduler bus: call buttons and core feedback in,
// dispatched target and status out.
// Optional feature macro: FIRE_RECALL_EN adds Fire_Recall / Fire_Active.
interface elevator_call_scheduler_if #(
    parameter int unsigned NUM_FLOORS = 16
) ();
    logic [NUM_FLOORS-1:0] Call_Req;
    logic [3:0]            Current_Floor;
    logic                  Complete;
    logic [3:0]            Request_Floor;
    logic                  Request_Valid;
    logic [NUM_FLOORS-1:0] Pending;
    logic                  Sweep_Dir;
    logic                  Stuck_Alert;
`ifdef FIRE_RECALL_EN
    logic                  Fire_Recall;
    logic                  Fire_Active;

    // Scheduler side
    modport master (
        input  Call_Req, Current_Floor, Complete, Fire_Recall,
        output Request_Floor, Request_Valid, Pending, Sweep_Dir, Stuck_Alert, Fire_Active
    );

    // Buttons / elevator core side
    modport slave (
        output Call_Req, Current_Floor, Complete, Fire_Recall,
        input  Request_Floor, Request_Valid, Pending, Sweep_Dir, Stuck_Alert, Fire_Active
    );
`else
    // Scheduler side
    modport master (
        input  Call_Req, Current_Floor, Complete,
        output Request_Floor, Request_Valid, Pending, Sweep_Dir, Stuck_Alert
    );

    // Buttons / elevator core side
    modport slave (
        output Call_Req, Current_Floor, Complete,
        input  Request_Floor, Request_Valid, Pending, Sweep_Dir, Stuck_Alert
    );
`endif
endinterface

// File: rtl/elevator_call_scheduler.sv
// Elevator call scheduler: latches floor calls into a pending bitmap,
// dispatches targets in SCAN order, retires on Complete at the target
// floor and raises Stuck_Alert if a dispatch waits too long.
// Optional feature macro: FIRE_RECALL_EN (fire-service recall to RECALL_FLOOR).
module elevator_call_scheduler #(
    parameter int unsigned NUM_FLOORS   = 16,
    parameter int unsigned WAIT_TIMEOUT = 600
`ifdef FIRE_RECALL_EN
    ,
    parameter int unsigned RECALL_FLOOR = 0
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    elevator_call_scheduler_if.master   bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_WAIT_DONE
    } state_t;

    localparam logic [3:0] LAST_FLOOR  = 4'(NUM_FLOORS - 1);
    localparam logic [9:0] TIMEOUT_CNT = (WAIT_TIMEOUT > 1023) ? 10'd1023 : 10'(WAIT_TIMEOUT);
`ifdef FIRE_RECALL_EN
    localparam logic [3:0] RECALL_IDX  = 4'(RECALL_FLOOR);
`endif

    state_t                r_state;
    logic [NUM_FLOORS-1:0] r_pending;
    logic [3:0]            r_req_floor;
    logic                  r_req_valid;
    logic                  r_sweep_dir;
    logic                  r_stuck;
    logic                  r_armed;
    logic [9:0]            r_timer;
`ifdef FIRE_RECALL_EN
    logic                  r_fire;
    logic                  w_fire_nxt;
`endif

    state_t                w_state_nxt;
    logic [NUM_FLOORS-1:0] w_pending_nxt;
    logic [3:0]            w_req_floor_nxt;
    logic                  w_req_valid_nxt;
    logic                  w_sweep_dir_nxt;
    logic                  w_stuck_nxt;
    logic                  w_armed_nxt;
    logic [9:0]            w_timer_nxt;

    logic [3:0]            w_cf;
    logic                  w_up_found;
    logic [3:0]            w_up_floor;
    logic                  w_dn_found;
    logic [3:0]            w_dn_floor;
    logic                  w_retire;
    logic [9:0]            w_timer_inc;
    logic [NUM_FLOORS-1:0] w_clear;
    logic [NUM_FLOORS-1:0] w_calls;

    // Clamp floor, locate nearest pending floor at/above and at/below it
    always_comb begin
        w_cf       = (bus.Current_Floor > LAST_FLOOR) ? LAST_FLOOR : bus.Current_Floor;
        w_up_found = 1'b0;
        w_up_floor = '0;
        w_dn_found = 1'b0;
        w_dn_floor = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (!w_up_found && r_pending[i] && (i >= 32'(w_cf))) begin
                w_up_found = 1'b1;
                w_up_floor = 4'(i);
            end
            if (r_pending[i] && (i <= 32'(w_cf))) begin
                w_dn_found = 1'b1;
                w_dn_floor = 4'(i);
            end
        end
    end

    // Next-state, dispatch, retire, watchdog and call capture
    always_comb begin
        w_state_nxt     = r_state;
        w_req_floor_nxt = r_req_floor;
        w_req_valid_nxt = r_req_valid;
        w_sweep_dir_nxt = r_sweep_dir;
        w_stuck_nxt     = r_stuck;
        w_armed_nxt     = r_armed;
        w_timer_nxt     = r_timer;
        w_retire        = 1'b0;
        w_timer_inc     = (r_timer == '1) ? r_timer : r_timer + 10'd1;
`ifdef FIRE_RECALL_EN
        w_fire_nxt      = bus.Fire_Recall;
`endif

        case (r_state)
            S_IDLE: begin
                if (|r_pending) begin
                    w_state_nxt = S_SELECT;
                end
            end
            S_SELECT: begin
                if (|r_pending) begin
                    if (r_sweep_dir) begin
                        if (w_up_found) begin
                            w_req_floor_nxt = w_up_floor;
                        end else begin
                            w_req_floor_nxt = w_dn_floor;
                            w_sweep_dir_nxt = 1'b0;
                        end
                    end else begin
                        if (w_dn_found) begin
                            w_req_floor_nxt = w_dn_floor;
                        end else begin
                            w_req_floor_nxt = w_up_floor;
                            w_sweep_dir_nxt = 1'b1;
                        end
                    end
                    w_req_valid_nxt = 1'b1;
                    w_armed_nxt     = 1'b0;
                    w_timer_nxt     = '0;
                    w_state_nxt     = S_WAIT_DONE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                // Armed gate: the core pulses Complete low even for a same-floor target
                if (r_armed && bus.Complete && (bus.Current_Floor == r_req_floor)) begin
                    w_retire        = 1'b1;
                    w_req_valid_nxt = 1'b0;
                    w_stuck_nxt     = 1'b0;
                    w_state_nxt     = S_IDLE;
                end else begin
                    if (!bus.Complete) begin
                        w_armed_nxt = 1'b1;
                    end
                    w_timer_nxt = w_timer_inc;
                    if (w_timer_inc == TIMEOUT_CNT) begin
                        w_stuck_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            w_clear[i] = w_retire && (r_req_floor == 4'(i));
        end
        w_calls       = bus.Call_Req;
        // Clear after set: a new call for the floor being retired is dropped
        w_pending_nxt = (r_pending | w_calls) & ~w_clear;

`ifdef FIRE_RECALL_EN
        // Recall overrides whatever the normal sweep decided this cycle
        if (bus.Fire_Recall && !r_fire) begin
            w_pending_nxt   = '0;
            w_req_floor_nxt = RECALL_IDX;
            w_req_valid_nxt = 1'b1;
            w_armed_nxt     = 1'b0;
            w_timer_nxt     = '0;
            w_state_nxt     = S_WAIT_DONE;
        end else if (r_fire && bus.Fire_Recall) begin
            w_pending_nxt = '0;
            if (w_retire) begin
                w_req_valid_nxt = 1'b1;
            end
        end else if (r_fire) begin
            w_pending_nxt   = '0;
            w_req_valid_nxt = 1'b0;
            w_armed_nxt     = 1'b0;
            w_timer_nxt     = '0;
            w_state_nxt     = S_IDLE;
        end
`endif
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_pending   <= '0;
            r_req_floor <= '0;
            r_req_valid <= 1'b0;
            r_sweep_dir <= 1'b1;
            r_stuck     <= 1'b0;
            r_armed     <= 1'b0;
            r_timer     <= '0;
`ifdef FIRE_RECALL_EN
            r_fire      <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_pending   <= w_pending_nxt;
            r_req_floor <= w_req_floor_nxt;
            r_req_valid <= w_req_valid_nxt;
            r_sweep_dir <= w_sweep_dir_nxt;
            r_stuck     <= w_stuck_nxt;
            r_armed     <= w_armed_nxt;
            r_timer     <= w_timer_nxt;
`ifdef FIRE_RECALL_EN
            r_fire      <= w_fire_nxt;
`endif
        end
    end

    assign bus.Request_Floor = r_req_floor;
    assign bus.Request_Valid = r_req_valid;
    assign bus.Pending       = r_pending;
    assign bus.Sweep_Dir     = r_sweep_dir;
    assign bus.Stuck_Alert   = r_stuck;
`ifdef FIRE_RECALL_EN
    assign bus.Fire_Active   = r_fire;
`endif

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler (WAIT_TIMEOUT overridden to 20).
// Recall scenario is built only when FIRE_RECALL_EN is defined.
module tb_elevator_call_scheduler;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    elevator_call_scheduler_if #(.NUM_FLOORS(16)) bus ();

    elevator_call_scheduler #(
        .NUM_FLOORS   (16),
        .WAIT_TIMEOUT (20)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse one call vector and advance to the cycle Request_Valid rises
    task automatic call_and_dispatch(input logic [15:0] calls);
        bus.Call_Req = calls;
        tick();
        bus.Call_Req = '0;
        tick();
        tick();
    endtask

    // Core arrives at floor f: Complete low for a cycle, then high
    task automatic serve(input logic [3:0] f);
        bus.Current_Floor = f;
        bus.Complete      = 1'b0;
        tick();
        bus.Complete      = 1'b1;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset             = 1'b0;
        bus.Call_Req      = 16'hFFFF;
        bus.Current_Floor = 4'd0;
        bus.Complete      = 1'b1;
`ifdef FIRE_RECALL_EN
        bus.Fire_Recall   = 1'b0;
`endif

        // 1 reset
        tick();
        tick();
        check_eq("rst_valid",   32'(bus.Request_Valid), 32'd0);
        check_eq("rst_floor",   32'(bus.Request_Floor), 32'd0);
        check_eq("rst_pending", 32'(bus.Pending),       32'd0);
        check_eq("rst_sweep",   32'(bus.Sweep_Dir),     32'd1);
        check_eq("rst_stuck",   32'(bus.Stuck_Alert),   32'd0);
        bus.Call_Req = '0;
        reset        = 1'b1;
        tick();
        check_eq("rel_pending", 32'(bus.Pending),       32'd0);
        check_eq("rel_valid",   32'(bus.Request_Valid), 32'd0);

        // 2 single call, latency
        bus.Current_Floor = 4'd2;
        bus.Call_Req      = 16'h0020;
        tick();
        bus.Call_Req = '0;
        check_eq("lat_pending", 32'(bus.Pending),       32'h0020);
        check_eq("lat_valid0",  32'(bus.Request_Valid), 32'd0);
        tick();
        check_eq("lat_valid1",  32'(bus.Request_Valid), 32'd0);
        tick();
        check_eq("lat_valid2",  32'(bus.Request_Valid), 32'd1);
        check_eq("lat_floor",   32'(bus.Request_Floor), 32'd5);
        serve(4'd5);
        check_eq("ret_pending", 32'(bus.Pending),       32'd0);
        check_eq("ret_valid",   32'(bus.Request_Valid), 32'd0);

        // 3 SCAN order from floor 4 sweeping up, pending {1,6,9}
        bus.Current_Floor = 4'd4;
        call_and_dispatch(16'h0242);
        check_eq("scan1_floor", 32'(bus.Request_Floor), 32'd6);
        check_eq("scan1_dir",   32'(bus.Sweep_Dir),     32'd1);
        serve(4'd6);
        check_eq("scan1_pend",  32'(bus.Pending),       32'h0202);
        tick();
        tick();
        check_eq("scan2_floor", 32'(bus.Request_Floor), 32'd9);
        check_eq("scan2_dir",   32'(bus.Sweep_Dir),     32'd1);
        serve(4'd9);
        tick();
        tick();
        check_eq("scan3_floor", 32'(bus.Request_Floor), 32'd1);
        check_eq("scan3_dir",   32'(bus.Sweep_Dir),     32'd0);
        serve(4'd1);
        check_eq("scan_done",   32'(bus.Pending),       32'd0);

        // 4 same floor: the initial Complete=1 must not retire
        bus.Current_Floor = 4'd3;
        call_and_dispatch(16'h0008);
        check_eq("same_floor",  32'(bus.Request_Floor), 32'd3);
        check_eq("same_valid",  32'(bus.Request_Valid), 32'd1);
        tick();
        tick();
        check_eq("same_hold",   32'(bus.Request_Valid), 32'd1);
        serve(4'd3);
        check_eq("same_retire", 32'(bus.Request_Valid), 32'd0);
        check_eq("same_pend",   32'(bus.Pending),       32'd0);

        // 5 watchdog: sweep down from 3 finds nothing, turns up to 7
        call_and_dispatch(16'h0080);
        check_eq("wd_floor",    32'(bus.Request_Floor), 32'd7);
        check_eq("wd_dir",      32'(bus.Sweep_Dir),     32'd1);
        bus.Complete = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        check_eq("wd_early",    32'(bus.Stuck_Alert),   32'd0);
        tick();
        check_eq("wd_alert",    32'(bus.Stuck_Alert),   32'd1);
        for (int i = 0; i < 5; i++) tick();
        check_eq("wd_sticky",   32'(bus.Stuck_Alert),   32'd1);
        check_eq("wd_held",     32'(bus.Request_Valid), 32'd1);
        // arrival, with a same-cycle call for 7 (dropped) and 2 (kept)
        bus.Current_Floor = 4'd7;
        bus.Complete      = 1'b1;
        bus.Call_Req      = 16'h0084;
        tick();
        bus.Call_Req = '0;
        check_eq("wd_clear",    32'(bus.Stuck_Alert),   32'd0);
        check_eq("wd_retire",   32'(bus.Request_Valid), 32'd0);
        check_eq("sim_pend",    32'(bus.Pending),       32'h0004);
        tick();
        tick();
        check_eq("sim_floor",   32'(bus.Request_Floor), 32'd2);
        check_eq("sim_dir",     32'(bus.Sweep_Dir),     32'd0);
        serve(4'd2);
        check_eq("sim_done",    32'(bus.Pending),       32'd0);

`ifdef FIRE_RECALL_EN
        // 6 fire recall while heading to 8 with {2,8} pending
        bus.Current_Floor = 4'd9;
        call_and_dispatch(16'h0104);
        check_eq("fr_floor8",   32'(bus.Request_Floor), 32'd8);
        bus.Fire_Recall = 1'b1;
        tick();
        check_eq("fr_active",   32'(bus.Fire_Active),   32'd1);
        check_eq("fr_redirect", 32'(bus.Request_Floor), 32'd0);
        check_eq("fr_pend",     32'(bus.Pending),       32'd0);
        bus.Call_Req = 16'hFFFF;
        tick();
        bus.Call_Req = '0;
        check_eq("fr_masked",   32'(bus.Pending),       32'd0);
        serve(4'd0);
        check_eq("fr_parked",   32'(bus.Request_Valid), 32'd1);
        check_eq("fr_still",    32'(bus.Fire_Active),   32'd1);
        bus.Fire_Recall = 1'b0;
        tick();
        check_eq("fr_off",      32'(bus.Fire_Active),   32'd0);
        check_eq("fr_off_pend", 32'(bus.Pending),       32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
